// File: rtl/mcr_input_pkg.sv
// mcr_input_pkg: shared types and default constants for the MCR per-frame input blocks
package mcr_input_pkg;
  typedef enum logic [1:0] {DIR_NONE, DIR_CW, DIR_CCW} spin_dir_t;
  localparam int SPIN_STEP_BTN   = 8;
  localparam int SPIN_ACC_PERIOD = 4;
  localparam int SPIN_MAX_STEP   = 8;
endpackage

// File: rtl/mcr_frame_tick.sv
// mcr_frame_tick: one-cycle frame tick on the rising edge of vsync
// Ports: clk_i core clock, rst_ni sync active-low reset, vsync_i video vsync,
//        tick_o high for the first cycle vsync is sampled high.
module mcr_frame_tick (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  output logic tick_o
);
  logic vs_q;
  always_ff @(posedge clk_i) vs_q <= rst_ni ? vsync_i : 1'b0;
  assign tick_o = vsync_i & ~vs_q;
endmodule

// File: rtl/mcr_spinner_accum.sv
// mcr_spinner_accum: per-frame rotate buttons to absolute 8-bit spinner angle with hold-to-accelerate
// Ports: clock_40/reset_n clock and sync active-low reset; btn_left/btn_right rotate requests;
//        btn_acc acceleration enable; use_spinner fine (1) or coarse (0) step; ctc_zc_to_2 vsync;
//        spin_angle accumulated angle; spin_moving last tick applied a nonzero step.
// Optional: define MCR_SPIN_PADDLE_EN to add paddle_delta/paddle_valid relative-motion input.
module mcr_spinner_accum
  import mcr_input_pkg::*;
#(
  parameter int ANGLE_W    = 8,
  parameter int STEP_BTN   = SPIN_STEP_BTN,
  parameter int ACC_PERIOD = SPIN_ACC_PERIOD,
  parameter int MAX_STEP   = SPIN_MAX_STEP
) (
  input  logic               clock_40,
  input  logic               reset_n,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_acc,
  input  logic               use_spinner,
  input  logic               ctc_zc_to_2,
`ifdef MCR_SPIN_PADDLE_EN
  input  logic [7:0]         paddle_delta,
  input  logic               paddle_valid,
`endif
  output logic [ANGLE_W-1:0] spin_angle,
  output logic               spin_moving
);
  localparam int HW = $clog2(ACC_PERIOD + 1);
  logic               tick, restart, acc, period_done;
  spin_dir_t          dir, last_dir_q, last_dir_d;
  logic [ANGLE_W-1:0] angle_q, angle_d, step_q, step_d, applied, move, paddle_add, step_sat;
  logic [HW-1:0]      hold_q, hold_d;
  logic               moving_q, moving_d;
  mcr_frame_tick u_frame_tick (
    .clk_i  (clock_40),
    .rst_ni (reset_n),
    .vsync_i(ctc_zc_to_2),
    .tick_o (tick)
  );
`ifdef MCR_SPIN_PADDLE_EN
  assign paddle_add = paddle_valid ? ANGLE_W'($signed(paddle_delta)) : '0;
`else
  assign paddle_add = '0;
`endif
  always_comb begin
    dir         = (btn_right & ~btn_left) ? DIR_CW : (btn_left & ~btn_right) ? DIR_CCW : DIR_NONE;
    restart     = (dir == DIR_NONE) || (dir != last_dir_q);
    acc         = use_spinner & btn_acc;
    period_done = hold_q == HW'(ACC_PERIOD - 1);
    step_sat    = (step_q >= ANGLE_W'(MAX_STEP)) ? ANGLE_W'(MAX_STEP) : step_q + ANGLE_W'(1);
    applied     = !use_spinner ? ANGLE_W'(STEP_BTN) : (acc && !restart) ? step_q : ANGLE_W'(1);
    move        = (dir == DIR_CW) ? applied : (dir == DIR_CCW) ? -applied : '0;
    angle_d     = angle_q + paddle_add;
    step_d      = step_q;
    hold_d      = hold_q;
    moving_d    = moving_q;
    last_dir_d  = last_dir_q;
    if (tick) begin
      angle_d    = angle_q + move + paddle_add;
      moving_d   = dir != DIR_NONE;
      last_dir_d = dir;
      // A restarting tick is the first held tick of the new step-1 period.
      step_d     = (!acc || restart) ? ANGLE_W'(1) : period_done ? step_sat : step_q;
      hold_d     = !acc ? '0 : restart ? HW'(1) : period_done ? '0 : hold_q + HW'(1);
    end
  end
  always_ff @(posedge clock_40) begin
    if (!reset_n) begin
      angle_q    <= '0;
      moving_q   <= 1'b0;
      step_q     <= ANGLE_W'(1);
      hold_q     <= '0;
      last_dir_q <= DIR_NONE;
    end else begin
      angle_q    <= angle_d;
      moving_q   <= moving_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      last_dir_q <= last_dir_d;
    end
  end
  assign spin_angle  = angle_q;
  assign spin_moving = moving_q;
endmodule

// File: tb/tb_mcr_spinner_accum.sv
// tb_mcr_spinner_accum: scoreboard bench for mcr_spinner_accum
module tb_mcr_spinner_accum;
  logic clk = 0, rst_n = 0, left = 0, right = 0, acc = 0, spin = 0, vs = 0;
  logic [7:0] angle;
  logic moving;
`ifdef MCR_SPIN_PADDLE_EN
  logic [7:0] pdelta = 0;
  logic pvalid = 0;
`endif
  int n_chk = 0, n_fail = 0;
  logic [8:0] exp_q[$];
  mcr_spinner_accum dut (
    .clock_40(clk), .reset_n(rst_n), .btn_left(left), .btn_right(right),
    .btn_acc(acc), .use_spinner(spin), .ctc_zc_to_2(vs),
`ifdef MCR_SPIN_PADDLE_EN
    .paddle_delta(pdelta), .paddle_valid(pvalid),
`endif
    .spin_angle(angle), .spin_moving(moving)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask
  task automatic tick(input int a, input logic m, input int len);
    exp_q.push_back({m, 8'(a)});
    @(negedge clk) vs = 1;
    repeat (len) @(negedge clk);
    vs = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic do_reset;
    @(negedge clk) rst_n = 0;
    @(negedge clk) rst_n = 1;
  endtask
  logic prev_vs = 0;
  always @(posedge clk) begin
    logic t;
    logic [8:0] e;
    t = rst_n && vs && !prev_vs;
    prev_vs = rst_n ? vs : 1'b0;
    if (t) begin
      #1;
      if (exp_q.size() == 0) begin
        chk("unexpected_tick", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("angle", int'(angle), int'(e[7:0]));
        chk("moving", int'(moving), int'(e[8]));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int a, st;
    repeat (3) @(negedge clk);
    chk("reset_angle", int'(angle), 0);
    chk("reset_moving", int'(moving), 0);
    rst_n = 1;
    for (int i = 0; i < 10; i++) tick(0, 0, 1);
    spin = 0; right = 1;
    tick(8, 1, 1);
    tick(16, 1, 1);
    tick(24, 1, 5);
    do_reset();
    spin = 1; acc = 1; a = 0;
    for (int k = 1; k <= 40; k++) begin
      st = (k - 1) / 4 + 1;
      if (st > 8) st = 8;
      a += st;
      if (k == 8 && a != 12) $display("bench table error");
      tick(a, 1, 1);
    end
    right = 0; left = 1;
    tick(207, 1, 1);
    do_reset();
    acc = 0; spin = 1; left = 1; right = 0;
    tick(255, 1, 1);
    left = 0; right = 1;
    tick(0, 1, 1);
    tick(1, 1, 1);
    left = 1;
    for (int i = 0; i < 5; i++) tick(1, 0, 1);
    left = 0; acc = 1;
    tick(2, 1, 1);
    tick(3, 1, 1);
    tick(4, 1, 1);
    tick(5, 1, 1);
    tick(7, 1, 1);
    tick(9, 1, 1);
    @(negedge clk) begin rst_n = 0; vs = 1; end
    @(negedge clk) begin rst_n = 1; vs = 0; end
    chk("rst_tick_angle", int'(angle), 0);
    chk("rst_tick_moving", int'(moving), 0);
    repeat (2) @(negedge clk);
    chk("rst_tick_discarded", int'(angle), 0);
    tick(1, 1, 1);
    tick(2, 1, 1);
    tick(3, 1, 1);
    tick(4, 1, 1);
    tick(6, 1, 1);
`ifdef MCR_SPIN_PADDLE_EN
    do_reset();
    acc = 0;
    for (int i = 1; i <= 10; i++) tick(i, 1, 1);
    exp_q.push_back({1'b1, 8'd8});
    @(negedge clk) begin vs = 1; pvalid = 1; pdelta = 8'hFD; end
    @(negedge clk) begin vs = 0; pvalid = 0; end
    repeat (2) @(negedge clk);
    @(negedge clk) begin pvalid = 1; pdelta = 8'd5; right = 0; end
    @(negedge clk) pvalid = 0;
    chk("paddle_only_angle", int'(angle), 13);
    chk("paddle_only_moving", int'(moving), 1);
`endif
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
